// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// and reconstructs the level word of a matched 2^BITS-cycle generator.
module pwm_capture #(
   parameter int WIDTH = 16,
   parameter int BITS  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period_cycles,
   output logic [WIDTH-1:0] high_cycles,
   output logic [BITS-1:0]  level_out,
   output logic             valid,
   output logic             locked,
   output logic             stalled
);

   localparam logic [WIDTH-1:0] PER_MAX = '1;
   localparam logic [WIDTH-1:0] TO_AT   = PER_MAX - WIDTH'(1);
   localparam logic [WIDTH-1:0] LOCK_P  = WIDTH'(2 ** BITS);
   localparam logic [WIDTH-1:0] LVL_TOP = WIDTH'(2 ** BITS - 1);

   typedef enum logic [1:0] {
      WAIT_RISE,
      IN_HIGH,
      IN_LOW
   } state_t;

   state_t           state;
   logic             s1, s, s_d;
   logic             rise, fall, timeout;
   logic [WIDTH-1:0] per, hi, per_p1;
   logic [BITS-1:0]  lvl_calc;

   assign rise    = s & ~s_d;
   assign fall    = ~s & s_d;
   assign timeout = (per == TO_AT) && !rise;
   assign per_p1  = per + WIDTH'(1);
   // 2^BITS-1-hi is the bitwise inverse of the low bits once hi fits
   assign lvl_calc = (hi > LVL_TOP) ? '0 : ~hi[BITS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= 1'b0;
         s   <= 1'b0;
         s_d <= 1'b0;
      end else begin
         s1  <= pwm_in;
         s   <= s1;
         s_d <= s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per <= '0;
         hi  <= '0;
      end else if (rise) begin
         per <= '0;
         hi  <= WIDTH'(1);
      end else begin
         if (per != PER_MAX) per <= per + WIDTH'(1);
         if (s && hi != PER_MAX) hi <= hi + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= WAIT_RISE;
         period_cycles <= '0;
         high_cycles   <= '0;
         level_out     <= '0;
         valid         <= 1'b0;
         locked        <= 1'b0;
         stalled       <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (rise) begin
            if (state == IN_LOW) begin
               period_cycles <= per_p1;
               high_cycles   <= hi;
               valid         <= 1'b1;
               stalled       <= 1'b0;
               locked        <= (per_p1 == LOCK_P);
               if (per_p1 == LOCK_P) level_out <= lvl_calc;
            end
            state <= IN_HIGH;
         end else if (timeout) begin
            period_cycles <= '0;
            high_cycles   <= '0;
            valid         <= 1'b1;
            stalled       <= 1'b1;
            locked        <= 1'b0;
            level_out     <= s ? '0 : '1;
            state         <= WAIT_RISE;
         end else begin
            unique case (state)
               IN_HIGH: if (fall) state <= IN_LOW;
               default: state <= state;
            endcase
         end
      end
   end

endmodule
